// File: rtl/uart_rx_if.sv
// Byte-side bundle of the 8N1 UART receiver.
// The master drives received data and status strobes.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_frame_err,
    input o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Frames restart on the first low after IDLE; no in-frame re-sync.
module uart_rx #(
  parameter int FREQ = 50_000_000,
  parameter int RATE = 115_200
) (
  input  logic     CLK,
  input  logic     rst_n,
  input  logic     i_rx,
  uart_rx_if.master bus
);

  localparam int DIV  = FREQ / RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx: FREQ/RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_q, data_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;

  assign rx_s = sync_q[1];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_rx};
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == DIV_M1) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == DIV_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = sh;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            // held-low line parks in BRK so a break is reported once
            ferr_n  = 1'b1;
            state_n = S_BRK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BRK: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first.
- Counterpart of the existing uart_tx. Sits directly downstream of the RXD pad in fpga_top.
- Converts the asynchronous serial line into byte-wide data with a one-cycle valid strobe and a framing-error strobe.
- Output feeds loopback/echo logic that drives uart_tx i_data/i_start.

Parameters:
- FREQ, 50_000_000, CLK frequency in Hz.
- RATE, 115_200, baud rate in bit/s.
- Derived (localparam, not overridable): DIV = FREQ/RATE (integer division; 434 at defaults), HALF = DIV/2 (217). Counter width = $clog2(DIV).
- DIV < 4 is illegal; elaboration must fail.

Ports:
- CLK, input, 1, system clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- i_rx, input, 1, raw serial line, asynchronous to CLK, idle high.
- o_data, output, 8, last correctly received byte.
- o_valid, output, 1, one-cycle strobe; o_data holds the new byte while it is high.
- o_frame_err, output, 1, one-cycle strobe; stop bit was sampled low.
- o_busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State = IDLE; sync flops = 1; counter = 0; bit index = 0; shift register = 0.
  - o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0.
- Synchronizer: i_rx passes through 2 flops to give rx_s. Only rx_s is used internally. This adds 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - t0 is the first cycle with rx_s == 0.
  - At t0: go to START, counter = 0.
- START:
  - Count to HALF-1, then sample rx_s at t0+HALF.
  - rx_s == 1: false start. Go to IDLE; no strobe.
  - rx_s == 0: go to DATA, counter = 0, bit index = 0.
- DATA:
  - Bit k (k = 0..7) is sampled at t0+HALF+(k+1)*DIV and shifted in LSB first.
  - After k = 7, go to STOP.
- STOP:
  - Sample rx_s at t0+HALF+9*DIV (mid stop bit).
  - rx_s == 1:
    - o_data <= shift register.
    - o_valid = 1 for exactly one cycle, at t0+HALF+9*DIV+1.
    - Go to IDLE.
  - rx_s == 0:
    - o_frame_err = 1 for exactly one cycle, same timing as o_valid.
    - o_data unchanged; no o_valid.
    - Go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. A line held low (break condition) must not generate repeated frames.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start bit that immediately follows the stop bit is detected with no lost byte.
- o_busy is combinational from state: (state != IDLE).
- o_valid and o_frame_err are never high in the same cycle. Both are registered.
- Sampling point tolerance: a baud mismatch of ±2% between sender and receiver must still decode correctly (mid-bit sampling, no re-sync within a frame).
- Reset mid-frame: all state clears immediately. The partial frame is discarded; no strobe is emitted after release.
  - After release, the receiver waits in IDLE for the next falling edge.
  - If the line is low at release, a false start is rejected or a frame error is produced; no corrupt o_valid is allowed.
- Counter never exceeds DIV-1; it reloads to 0 at each sample point.

Test Plan:
- Defaults (DIV = 434), drive frame 0x55 with ideal timing.
  -> one o_valid pulse at t0+217+9*434+1 (counted from the synchronized edge); o_data = 8'h55; o_frame_err stays 0; o_busy high for the frame, then 0.
- Back-to-back 0x30 and 0x31, no idle gap between stop and next start.
  -> two o_valid pulses 4340 cycles apart; o_data = 8'h30, then 8'h31.
- Low glitch of 100 cycles on i_rx, then line high.
  -> START rejects it at HALF; no o_valid, no o_frame_err; o_busy high for about 217 cycles, then 0.
- Frame 0xA5 with stop bit driven 0, line held low for 2000 more cycles, then high, then frame 0x42.
  -> a single o_frame_err pulse; o_data keeps its previous value; no further strobes while low; then o_valid with o_data = 8'h42.
- rst_n pulsed low during data bit 3 of frame 0x99, released with line high, then frame 0x7E.
  -> o_busy = 0 and o_valid = 0 immediately on reset; no strobe for 0x99; o_valid with o_data = 8'h7E.
- Frame 0xC3 sent at bit period 443, then again at bit period 425 (about ±2%).
  -> both decode as 8'hC3 with no o_frame_err.
